// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C transaction scheduler and its arbiter.
package i2c_sched_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef struct packed {
    logic        rnw;
    logic [7:0]  reg_addr;
    logic [15:0] wdata;
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GUARD
  } sched_state_t;

  // Wide enough for the 20 ms timeout at 100 MHz and for the guard gap.
  localparam int c_TIMEOUT_CNT_W = 32;

  function automatic i2c_cmd_t make_cmd(input logic        rnw,
                                        input logic [7:0]  reg_addr,
                                        input logic [15:0] wdata);
    i2c_cmd_t cmd;
    cmd.rnw      = rnw;
    cmd.reg_addr = reg_addr;
    cmd.wdata    = wdata;
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_transaction_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer,
// pointer moves past the current owner when advance is strobed.
module rr_arbiter
  import i2c_sched_pkg::*;
#(
  parameter int g_n = 4
) (
  input  ckrs_t          clk_rs,
  input  logic [g_n-1:0] req,
  input  logic [g_n-1:0] owner,
  input  logic           advance,
  output logic [g_n-1:0] pick,
  output logic           pick_valid
);

  localparam int c_PTR_W = (g_n > 1) ? $clog2(g_n) : 1;

  logic [c_PTR_W-1:0] ptr;
  logic [c_PTR_W-1:0] ptr_next;

  // Scan g_n positions starting at ptr; the first set request wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < g_n; i++) begin
      idx = int'(ptr) + i;
      if (idx >= g_n) begin
        idx = idx - g_n;
      end
      for (int j = 0; j < g_n; j++) begin
        if (idx == j && req[j] && !pick_valid) begin
          pick[j]    = 1'b1;
          pick_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    for (int j = 0; j < g_n; j++) begin
      if (owner[j]) begin
        ptr_next = (j == g_n - 1) ? '0 : c_PTR_W'(j + 1);
      end
    end
  end

  always_ff @(posedge clk_rs.clk) begin
    if (!clk_rs.reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/i2c_transaction_scheduler.sv
// Shares one byte-level I2C master between several requesters: round-robin grant,
// one register transaction per grant, master timeout and an idle guard gap.
module i2c_transaction_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int g_requesters     = 4,
  parameter int g_timeout_cycles = 2000000,
  parameter int g_guard_cycles   = 100
) (
  input  ckrs_t                         ClkRs_ix,
  input  logic [g_requesters-1:0]       Req_ib,
  input  logic [g_requesters-1:0]       Rnw_ib,
  input  logic [g_requesters-1:0][7:0]  Reg_ib8,
  input  logic [g_requesters-1:0][15:0] WData_ib16,
  output logic [g_requesters-1:0]       Grant_ob,
  output logic [g_requesters-1:0]       Done_ob,
  output logic [g_requesters-1:0]       Error_ob,
  output logic [15:0]                   RData_ob16,
  output logic                          MStart_o,
  output logic                          MAbort_o,
  output logic                          MRnw_o,
  output logic [7:0]                    MReg_ob8,
  output logic [15:0]                   MWData_ob16,
  input  logic                          MBusy_i,
  input  logic                          MDone_i,
  input  logic                          MError_i,
  input  logic [15:0]                   MRData_ib16,
  output logic [7:0]                    TimeoutCnt_ob8
);

  localparam logic [c_TIMEOUT_CNT_W-1:0] c_TMO_LAST   = c_TIMEOUT_CNT_W'(g_timeout_cycles - 1);
  localparam logic [c_TIMEOUT_CNT_W-1:0] c_GUARD_LAST = c_TIMEOUT_CNT_W'(g_guard_cycles - 1);

  sched_state_t                state;
  i2c_cmd_t                    cmd_sel;
  i2c_cmd_t                    cmd_q;
  logic [g_requesters-1:0]     pick;
  logic                        pick_valid;
  logic                        advance;
  logic [c_TIMEOUT_CNT_W-1:0]  tmo_cnt;
  logic [c_TIMEOUT_CNT_W-1:0]  guard_cnt;

  assign advance = (state == RESP);

  rr_arbiter #(
    .g_n (g_requesters)
  ) u_arbiter (
    .clk_rs     (ClkRs_ix),
    .req        (Req_ib),
    .owner      (Grant_ob),
    .advance    (advance),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < g_requesters; i++) begin
      if (pick[i]) begin
        cmd_sel = make_cmd(Rnw_ib[i], Reg_ib8[i], WData_ib16[i]);
      end
    end
  end

  // The latched command is held after the transaction so the master sees stable inputs.
  assign MRnw_o      = cmd_q.rnw;
  assign MReg_ob8    = cmd_q.reg_addr;
  assign MWData_ob16 = cmd_q.wdata;

  // Done/Error/RData are registered on leaving WAIT so they pulse during RESP.
  always_ff @(posedge ClkRs_ix.clk) begin
    if (!ClkRs_ix.reset) begin
      state          <= IDLE;
      cmd_q          <= '0;
      Grant_ob       <= '0;
      Done_ob        <= '0;
      Error_ob       <= '0;
      RData_ob16     <= '0;
      MStart_o       <= 1'b0;
      MAbort_o       <= 1'b0;
      TimeoutCnt_ob8 <= '0;
      tmo_cnt        <= '0;
      guard_cnt      <= '0;
    end else begin
      MStart_o <= 1'b0;
      MAbort_o <= 1'b0;
      Done_ob  <= '0;
      Error_ob <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            Grant_ob <= pick;
            cmd_q    <= cmd_sel;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!MBusy_i) begin
            MStart_o <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A completion in the expiry cycle takes precedence over the timeout.
          if (MDone_i) begin
            Done_ob    <= Grant_ob;
            Error_ob   <= MError_i ? Grant_ob : '0;
            RData_ob16 <= MRData_ib16;
            state      <= RESP;
          end else if (tmo_cnt == c_TMO_LAST) begin
            MAbort_o <= 1'b1;
            Done_ob  <= Grant_ob;
            Error_ob <= Grant_ob;
            if (TimeoutCnt_ob8 != 8'hFF) begin
              TimeoutCnt_ob8 <= TimeoutCnt_ob8 + 8'd1;
            end
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          Grant_ob  <= '0;
          guard_cnt <= '0;
          state     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt == c_GUARD_LAST) begin
            state <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_transaction_scheduler.sv
// Scoreboard bench: a master model answers each start, expected completions are
// queued from a round-robin reference and checked by an independent monitor.
module tb_i2c_transaction_scheduler;
  import i2c_sched_pkg::*;

  localparam int N = 4;
  localparam int T = 300;
  localparam int G = 100;

  typedef struct {
    int          idx;
    bit          err;
    bit          chk_rdata;
    logic [15:0] rdata;
    logic [7:0]  tmo;
  } exp_t;

  logic clk;
  logic rst_n;
  ckrs_t clk_rs;

  logic [N-1:0]       req;
  logic [N-1:0]       rnw;
  logic [N-1:0][7:0]  reg_addr;
  logic [N-1:0][15:0] wdata;
  logic [N-1:0]       Grant_ob;
  logic [N-1:0]       Done_ob;
  logic [N-1:0]       Error_ob;
  logic [15:0]        RData_ob16;
  logic               MStart_o;
  logic               MAbort_o;
  logic               MRnw_o;
  logic [7:0]         MReg_ob8;
  logic [15:0]        MWData_ob16;
  logic               MBusy_i;
  logic               MDone_i;
  logic               MError_i;
  logic [15:0]        MRData_ib16;
  logic [7:0]         TimeoutCnt_ob8;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cycle = 0;
  int   done_cycle = -1;
  int   grant_cycle = 0;
  int   model_ptr = 0;
  logic [7:0] model_tmo = 8'd0;
  int   last_w = 0;
  int   starts_exp = 0;
  int   starts_seen = 0;
  exp_t exp_q[$];

  assign clk_rs = '{clk: clk, reset: rst_n};

  i2c_transaction_scheduler #(
    .g_requesters     (N),
    .g_timeout_cycles (T),
    .g_guard_cycles   (G)
  ) dut (
    .ClkRs_ix       (clk_rs),
    .Req_ib         (req),
    .Rnw_ib         (rnw),
    .Reg_ib8        (reg_addr),
    .WData_ib16     (wdata),
    .Grant_ob       (Grant_ob),
    .Done_ob        (Done_ob),
    .Error_ob       (Error_ob),
    .RData_ob16     (RData_ob16),
    .MStart_o       (MStart_o),
    .MAbort_o       (MAbort_o),
    .MRnw_o         (MRnw_o),
    .MReg_ob8       (MReg_ob8),
    .MWData_ob16    (MWData_ob16),
    .MBusy_i        (MBusy_i),
    .MDone_i        (MDone_i),
    .MError_i       (MError_i),
    .MRData_ib16    (MRData_ib16),
    .TimeoutCnt_ob8 (TimeoutCnt_ob8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference arbitration: first pending requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_state(input string tag);
    check_output({tag, "_grant_done_err"}, {Grant_ob, Done_ob, Error_ob}, 0);
    check_output({tag, "_strobes"}, {MStart_o, MAbort_o}, 0);
    check_output({tag, "_cmd"}, {MRnw_o, MReg_ob8, MWData_ob16}, 0);
    check_output({tag, "_rdata_tmo"}, {RData_ob16, TimeoutCnt_ob8}, 0);
  endtask

  // kind: 0 = normal reply after dly clocks, 1 = no reply (timeout), 2 = reply on the expiry cycle
  task automatic apply_stimulus(input int kind, input int dly, input bit merr,
                                input logic [15:0] mrdata, input int busy);
    int   w;
    int   rel;
    int   abort_at;
    int   reply_at;
    bit   got;
    bit   early;
    exp_t e;
    w = rr_pick(req, model_ptr);
    last_w = (w < 0) ? 0 : w;
    starts_exp++;
    MBusy_i = (busy > 0);
    got = 1'b0;
    for (int i = 0; i < G + 50; i++) begin
      @(negedge clk);
      if (i == 3) begin
        MDone_i = 1'b1;
        MError_i = 1'($urandom);
        MRData_ib16 = 16'($urandom);
      end else begin
        MDone_i = 1'b0;
      end
      if (Grant_ob != '0) begin
        got = 1'b1;
        break;
      end
    end
    MDone_i = 1'b0;
    check_output("grant_seen", 32'(got), 1);
    if (!got) return;
    grant_cycle = cycle;
    check_output("grant_order", 32'(Grant_ob), 32'd1 << last_w);
    if (done_cycle >= 0) check_output("guard_gap_ok", 32'((cycle - done_cycle) >= G), 1);
    check_output("cmd_at_grant", {MRnw_o, MReg_ob8, MWData_ob16},
                 {rnw[last_w], reg_addr[last_w], wdata[last_w]});
    early = 1'b0;
    for (int i = 0; i < busy; i++) begin
      if (MStart_o) early = 1'b1;
      @(negedge clk);
    end
    if (MStart_o) early = 1'b1;
    MBusy_i = 1'b0;
    rel = cycle;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (MStart_o) begin
        got = 1'b1;
        break;
      end
    end
    check_output("start_while_busy", 32'(early), 0);
    check_output("start_latency", got ? (cycle - rel) : -1, 1);
    if (!got) return;
    e.idx = last_w;
    e.err = (kind == 1) ? 1'b1 : merr;
    e.chk_rdata = (kind != 1) && !merr && rnw[last_w];
    e.rdata = mrdata;
    if (kind == 1 && model_tmo != 8'hFF) model_tmo = model_tmo + 8'd1;
    e.tmo = model_tmo;
    exp_q.push_back(e);
    reply_at = (kind == 2) ? (T - 1) : dly;
    abort_at = -1;
    got = 1'b0;
    for (int j = 0; j < T + 50; j++) begin
      if (MAbort_o && abort_at < 0) abort_at = j;
      if (Done_ob != '0) begin
        got = 1'b1;
        break;
      end
      if (kind != 1 && j == reply_at) begin
        MDone_i = 1'b1;
        MError_i = merr;
        MRData_ib16 = mrdata;
      end else begin
        MDone_i = 1'b0;
        MError_i = 1'($urandom);
        MRData_ib16 = 16'($urandom);
      end
      @(negedge clk);
    end
    MDone_i = 1'b0;
    check_output("done_seen", 32'(got), 1);
    check_output("abort_offset", abort_at, (kind == 1) ? T : -1);
    check_output("cmd_hold", {MRnw_o, MReg_ob8, MWData_ob16},
                 {rnw[last_w], reg_addr[last_w], wdata[last_w]});
    done_cycle = cycle;
    model_ptr = (last_w + 1) % N;
  endtask

  task automatic refresh_requests(input int w);
    logic [N-1:0] nxt;
    int k;
    nxt = req;
    nxt[w] = ($urandom_range(0, 9) < 3);
    for (int i = 0; i < N; i++) begin
      if (!nxt[i] && $urandom_range(0, 3) == 0) nxt[i] = 1'b1;
    end
    if (nxt == '0) begin
      k = $urandom_range(0, N - 1);
      nxt[k] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == w || !req[i]) begin
        rnw[i] = 1'($urandom);
        reg_addr[i] = 8'($urandom);
        wdata[i] = 16'($urandom);
      end
    end
    req = nxt;
  endtask

  task automatic set_single(input int i, input logic r, input logic [7:0] a, input logic [15:0] d);
    req = '0;
    req[i] = 1'b1;
    rnw[i] = r;
    reg_addr[i] = a;
    wdata[i] = d;
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && MStart_o) starts_seen++;
      if (rst_n && Done_ob != '0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 32'(Done_ob), 0);
        end else begin
          e = exp_q.pop_front();
          check_output("done_onehot", 32'(Done_ob), 32'd1 << e.idx);
          check_output("error_flag", 32'(Error_ob), e.err ? (32'd1 << e.idx) : 0);
          if (e.chk_rdata) check_output("read_data", 32'(RData_ob16), 32'(e.rdata));
          check_output("timeout_count", 32'(TimeoutCnt_ob8), 32'(e.tmo));
        end
      end
    end
  end

  initial begin
    int kind;
    int r;
    int req_at;
    bit got;
    rst_n = 1'b0;
    req = '0;
    rnw = '0;
    reg_addr = '0;
    wdata = '0;
    MBusy_i = 1'b0;
    MDone_i = 1'b0;
    MError_i = 1'b0;
    MRData_ib16 = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single read");
    set_single(0, 1'b1, 8'h05, 16'h0000);
    req_at = cycle;
    apply_stimulus(0, 50, 1'b0, 16'h1A2B, 0);
    check_output("grant_latency", grant_cycle - req_at, 1);

    $display("[TB] round robin");
    req = '1;
    for (int i = 0; i < N; i++) begin
      rnw[i] = 1'b1;
      reg_addr[i] = 8'(8'h10 + i);
    end
    for (int t = 0; t < 5; t++) begin
      apply_stimulus(0, $urandom_range(0, 40), 1'b0, 16'($urandom), 0);
      reg_addr[last_w] = 8'($urandom);
    end

    $display("[TB] write nack");
    set_single(2, 1'b0, 8'h22, 16'hBEEF);
    apply_stimulus(0, 20, 1'b1, 16'h5555, 0);

    $display("[TB] busy master");
    set_single(1, 1'b1, 8'h31, 16'h0000);
    apply_stimulus(0, 10, 1'b0, 16'h7E57, 30);

    $display("[TB] timeout and tie");
    set_single(3, 1'b1, 8'h40, 16'h0000);
    apply_stimulus(1, 0, 1'b0, 16'h0000, 0);
    set_single(0, 1'b1, 8'h41, 16'h0000);
    apply_stimulus(2, 0, 1'b0, 16'hC0DE, 0);

    $display("[TB] random traffic");
    refresh_requests(last_w);
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 99);
      kind = (r < 82) ? 0 : (r < 91) ? 1 : 2;
      apply_stimulus(kind, $urandom_range(0, 60), ($urandom_range(0, 3) == 0), 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
      refresh_requests(last_w);
    end

    $display("[TB] reset during wait");
    set_single(1, 1'b1, 8'h51, 16'h0000);
    apply_stimulus(0, 5, 1'b0, 16'h1111, 0);
    req = '1;
    starts_exp++;
    got = 1'b0;
    for (int i = 0; i < G + 50; i++) begin
      @(negedge clk);
      if (MStart_o) begin
        got = 1'b1;
        break;
      end
    end
    check_output("pre_reset_start", 32'(got), 1);
    check_output("pre_reset_grant", 32'(Grant_ob), 32'd1 << rr_pick(req, model_ptr));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    model_ptr = 0;
    model_tmo = 8'd0;
    done_cycle = -1;
    apply_stimulus(0, 8, 1'b0, 16'h2222, 0);
    repeat (5) @(negedge clk);

    check_output("start_count", starts_seen, starts_exp);
    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
